// File: rtl/cycle_meas_arb.sv
`default_nettype none
// ============================================================================
// cycle_meas_arb: round-robin arbiter for one shared cycle-measurement window
// Revision: 1.0
// ============================================================================
module cycle_meas_arb #(
    parameter  int NREQ = 4,
    parameter  int W    = 32,
    parameter  int TMO  = 1000000,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    cnt_in,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [IDW-1:0]  res_id,
    output logic [W-1:0]    res_cycles,
    output logic            res_timeout
);

    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t          r_state, w_state;
    logic [NREQ-1:0] r_gnt, w_gnt;
    logic [IDW-1:0]  r_owner, w_owner;
    logic [IDW-1:0]  r_last, w_last;
    logic [W-1:0]    r_start_ts, w_start_ts;
    logic [TW-1:0]   r_tcnt, w_tcnt;
    logic            r_res_valid, w_res_valid;
    logic [IDW-1:0]  r_res_id, w_res_id;
    logic [W-1:0]    r_res_cycles, w_res_cycles;
    logic            r_res_timeout, w_res_timeout;

    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(r_last) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state       = r_state;
        w_gnt         = r_gnt;
        w_owner       = r_owner;
        w_last        = r_last;
        w_start_ts    = r_start_ts;
        w_tcnt        = r_tcnt;
        w_res_valid   = r_res_valid;
        w_res_id      = r_res_id;
        w_res_cycles  = r_res_cycles;
        w_res_timeout = r_res_timeout;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state    = MEAS;
                    w_gnt      = NREQ'(1) << w_win;
                    w_owner    = w_win;
                    w_last     = w_win;
                    w_start_ts = cnt_in;
                    w_tcnt     = '0;
                end
            end
            MEAS: begin
                // The owner's done takes priority over a coincident timeout.
                if (done[r_owner]) begin
                    w_state       = REPORT;
                    w_gnt         = '0;
                    w_res_valid   = 1'b1;
                    w_res_id      = r_owner;
                    w_res_cycles  = cnt_in - r_start_ts;
                    w_res_timeout = 1'b0;
                end else if (r_tcnt == TW'(TMO - 1)) begin
                    w_state       = REPORT;
                    w_gnt         = '0;
                    w_res_valid   = 1'b1;
                    w_res_id      = r_owner;
                    w_res_cycles  = W'(TMO);
                    w_res_timeout = 1'b1;
                end else begin
                    w_tcnt = r_tcnt + TW'(1);
                end
            end
            REPORT: begin
                if (res_ready) begin
                    w_state       = IDLE;
                    w_res_valid   = 1'b0;
                    w_res_id      = '0;
                    w_res_cycles  = '0;
                    w_res_timeout = 1'b0;
                end
            end
            default: begin
                w_state = IDLE;
                w_gnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_owner       <= '0;
            r_last        <= IDW'(NREQ - 1);
            r_start_ts    <= '0;
            r_tcnt        <= '0;
            r_res_valid   <= 1'b0;
            r_res_id      <= '0;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_gnt         <= w_gnt;
            r_owner       <= w_owner;
            r_last        <= w_last;
            r_start_ts    <= w_start_ts;
            r_tcnt        <= w_tcnt;
            r_res_valid   <= w_res_valid;
            r_res_id      <= w_res_id;
            r_res_cycles  <= w_res_cycles;
            r_res_timeout <= w_res_timeout;
        end
    end

    assign gnt         = r_gnt;
    assign busy        = (r_state != IDLE);
    assign res_valid   = r_res_valid;
    assign res_id      = r_res_id;
    assign res_cycles  = r_res_cycles;
    assign res_timeout = r_res_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cycle_meas_arb.sv
`default_nettype none
// ============================================================================
// tb_cycle_meas_arb: scoreboard bench for cycle_meas_arb (NREQ=4, W=32, TMO=8)
// Revision: 1.0
// ============================================================================
module tb_cycle_meas_arb;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    cnt_in;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_id;
    logic [W-1:0]    res_cycles;
    logic            res_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] cyc;
        logic         to;
    } exp_t;

    exp_t sb[$];

    cycle_meas_arb #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_cycles  (res_cycles),
        .res_timeout (res_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},   gnt, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_id"},    res_id, 0);
        check({tag, "_cyc"},   res_cycles, 0);
        check({tag, "_to"},    res_timeout, 0);
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] cyc, input logic to);
        exp_t e;
        e.id  = 2'(id);
        e.cyc = cyc;
        e.to  = to;
        sb.push_back(e);
    endtask

    // Arbitration edge: drive req and the start timestamp, then expect the grant.
    task automatic arb(input string tag, input logic [3:0] r, input int idx, input logic [W-1:0] start);
        req    = r;
        cnt_in = start;
        tick();
        check({tag, "_gnt"},  gnt, 64'd1 << idx);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic finish_done(input int idx, input logic [W-1:0] endc, input logic [W-1:0] expc);
        done   = 4'(1 << idx);
        cnt_in = endc;
        push_exp(idx, expc, 1'b0);
        tick();
        done = '0;
    endtask

    task automatic wait_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, res_valid, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_id"},  res_id, e.id);
            check({tag, "_cyc"}, res_cycles, e.cyc);
            check({tag, "_to"},  res_timeout, e.to);
        end else begin
            check({tag, "_sb_nonempty"}, sb.size(), 1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_after_valid"}, res_valid, 0);
        check({tag, "_after_gnt"},   gnt, 0);
        check({tag, "_after_busy"},  busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cnt_in    = '0;
        req       = '0;
        done      = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;

        // Idle with no requests, res_ready noise has no effect.
        res_ready = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        check_zero("idle");

        // Basic measurement; req drop and change in MEAS are ignored.
        arb("basic", 4'b0001, 0, 32'd100);
        req    = 4'b1110;
        cnt_in = 32'd120;
        tick();
        check("basic_hold_gnt", gnt, 4'b0001);
        req = '0;
        finish_done(0, 32'd150, 32'd50);
        wait_result("basic");

        // Round robin after a grant to 0 skips 1 and lands on 2.
        arb("rr0101", 4'b0101, 2, 32'd200);
        req = '0;
        finish_done(2, 32'd203, 32'd3);
        wait_result("rr0101");

        // Reset mid-MEAS, asserted together with the owner's done.
        arb("pre_rst", 4'b1000, 3, 32'd400);
        tick();
        rst  = 1'b1;
        req  = 4'b1111;
        done = 4'b1000;
        cnt_in = 32'd410;
        tick();
        rst  = 1'b0;
        req  = '0;
        done = '0;
        check_zero("midrst");
        repeat (3) tick();
        check("midrst_no_result", res_valid, 0);
        check("midrst_idle", busy, 0);

        // Four windows with all requesters held: grant order 0,1,2,3.
        for (int i = 0; i < 4; i++) begin
            arb($sformatf("rr1111_%0d", i), 4'b1111, i, 32'(1000 + 100 * i));
            finish_done(i, 32'(1000 + 100 * i + i + 2), 32'(i + 2));
            wait_result($sformatf("rr1111_%0d", i));
        end
        req = '0;

        // Counter wrap between start and done.
        arb("wrap", 4'b0001, 0, 32'hFFFF_FFF0);
        req = '0;
        finish_done(0, 32'h0000_0010, 32'd32);
        wait_result("wrap");

        // Timeout: result appears after the 8th MEAS cycle.
        arb("tmo", 4'b0010, 1, 32'd300);
        req = '0;
        push_exp(1, 32'(TMO), 1'b1);
        repeat (TMO - 1) tick();
        check("tmo_early_valid", res_valid, 0);
        check("tmo_early_gnt", gnt, 4'b0010);
        tick();
        check("tmo_on_time", res_valid, 1);
        wait_result("tmo");

        // Done in the 8th MEAS cycle beats the timeout.
        arb("tmo_done", 4'b0100, 2, 32'd1000);
        req = '0;
        repeat (TMO - 1) tick();
        finish_done(2, 32'd1007, 32'd7);
        wait_result("tmo_done");

        // Non-owner done noise, then backpressure in REPORT.
        arb("bp", 4'b1000, 3, 32'd500);
        req       = 4'b1111;
        done      = 4'b0111;
        res_ready = 1'b1;
        cnt_in    = 32'd505;
        tick();
        done      = '0;
        res_ready = 1'b0;
        check("bp_noise_busy", busy, 1);
        check("bp_noise_gnt", gnt, 4'b1000);
        check("bp_noise_valid", res_valid, 0);
        finish_done(3, 32'd520, 32'd20);
        for (int i = 0; i < 5; i++) begin
            done   = 4'(i + 1);
            cnt_in = 32'(900 + i);
            tick();
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_id", res_id, 3);
            check("bp_hold_cyc", res_cycles, 32'd20);
            check("bp_hold_to", res_timeout, 0);
            check("bp_no_gnt", gnt, 0);
        end
        done = '0;
        wait_result("bp");
        req = '0;

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cycle_meas_arb.md
CYCLE_MEAS_ARB -- requirements
Module: cycle_meas_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter W, default 32: timestamp and result width.
REQ-003 Parameter TMO, default 1000000: maximum measurement length in MEAS cycles.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cnt_in  input  W  free-running cycle-count value from the shared counter.
REQ-007 req  input  NREQ  per-requester measurement request, level, held until granted.
REQ-008 done  input  NREQ  per-requester end-of-region strobe.
REQ-009 gnt  output  NREQ  one-hot grant of the shared measurement window.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_id  output  log2(NREQ)  index of the measured requester.
REQ-014 res_cycles  output  W  elapsed cycle count.
REQ-015 res_timeout  output  1  measurement ended by timeout.

Function
REQ-016 The block SHALL implement exactly three states: IDLE, MEAS and REPORT.
REQ-017 In IDLE with any req bit set, arbitration SHALL be round-robin, searching from index (last_grant+1) mod NREQ.
REQ-018 The arbitration edge SHALL register gnt one-hot for the winner, capture start_ts = cnt_in and clear tcnt to 0.
REQ-019 The arbitration edge SHALL move the state to MEAS, giving 1-cycle req->gnt latency.
REQ-020 last_grant SHALL update only on a grant.
REQ-021 After reset, last_grant SHALL equal NREQ-1, so requester 0 wins the first contention.
REQ-022 In IDLE with req all-zero, the block SHALL hold its state and keep all outputs at their reset values.
REQ-023 In MEAS, gnt SHALL stay constant, and req changes or deassertion SHALL have no effect.
REQ-024 In MEAS, done bits of non-owners SHALL be ignored.
REQ-025 In MEAS, done[owner]=1 at cycle t SHALL register res_cycles = cnt_in(t) - start_ts, modulo 2^W.
REQ-026 The subtraction in REQ-025 SHALL be correct across cnt_in wrap-around.
REQ-027 On done[owner], the block SHALL set res_timeout=0, res_id=owner, res_valid=1 and gnt=0, and go to REPORT.
REQ-028 In MEAS with no done[owner] and tcnt == TMO-1, the block SHALL set res_cycles=TMO, res_timeout=1, res_id=owner, res_valid=1 and gnt=0, and go to REPORT.
REQ-029 In MEAS with no done[owner] and tcnt < TMO-1, tcnt SHALL increment by 1.
REQ-030 When done[owner] and the timeout condition occur in the same cycle, done SHALL win and res_timeout SHALL be 0.
REQ-031 In REPORT, res_valid, res_id, res_cycles and res_timeout SHALL be held stable until res_valid && res_ready.
REQ-032 On res_valid && res_ready, res_valid SHALL be 0 next cycle and the state SHALL be IDLE.
REQ-033 Arbitration SHALL NOT occur in the REPORT->IDLE cycle; the next grant comes at the earliest one cycle later.
REQ-034 res_ready outside REPORT SHALL have no effect.
REQ-035 No grant SHALL be issued in MEAS or REPORT.
REQ-036 gnt SHALL never have more than one bit set.
REQ-037 tcnt SHALL be at least ceil(log2(TMO+1)) bits wide, and TMO SHALL be at least 1.

Reset
REQ-038 With rst=1 at an edge, the block SHALL enter IDLE from any state, including mid-MEAS and mid-REPORT.
REQ-039 With rst=1 at an edge, gnt, busy, res_valid, res_id, res_cycles, res_timeout, start_ts and tcnt SHALL all be 0, and last_grant SHALL be NREQ-1.
REQ-040 Any measurement in progress at reset SHALL be discarded with no result reported.
REQ-041 Reset SHALL dominate all other inputs in the same cycle.

Verification
REQ-042 Basic: req=0001, cnt_in=100 at the arbitration edge; done[0] at cnt_in=150 -> gnt=0001 one cycle after req, res_cycles=50, res_id=0, res_timeout=0.
REQ-043 Round-robin: req=1111 held through four windows -> grant order 0,1,2,3; with req=0101 after a grant to 0 -> next grant 2.
REQ-044 Wrap: start_ts=32'hFFFF_FFF0, done at cnt_in=32'h0000_0010 -> res_cycles=32.
REQ-045 Timeout: TMO=8, no done -> res_valid in the cycle after the 8th MEAS cycle, res_cycles=8, res_timeout=1; with done[owner] in the 8th MEAS cycle -> res_timeout=0.
REQ-046 Backpressure and noise: res_ready=0 for 5 cycles -> outputs stable and no new gnt; done from a non-owner in MEAS -> ignored.
REQ-047 Reset mid-MEAS: rst pulsed for 1 cycle -> all outputs 0 next cycle, no result, and the next contention with req=1111 grants requester 0.
